// File: rtl/cam_frame_sched_if.sv
// rtl/cam_frame_sched_if.sv - local write-command bus between frame scheduler and AXI master
interface cam_frame_sched_if;
   logic        WR_START;
   logic [31:0] WR_ADRS;
   logic [31:0] WR_LEN;
   logic        WR_READY;
   logic        WR_DONE;

   // Scheduler side issues line writes
   modport master (
      output WR_START,
      output WR_ADRS,
      output WR_LEN,
      input  WR_READY,
      input  WR_DONE
   );

   // AXI master side executes them
   modport slave (
      input  WR_START,
      input  WR_ADRS,
      input  WR_LEN,
      output WR_READY,
      output WR_DONE
   );
endinterface

// File: rtl/cam_frame_sched.sv
// rtl/cam_frame_sched.sv - triple-buffered camera frame write scheduler with reader lock
module cam_frame_sched #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter logic [31:0] FRAME_STRIDE = 32'h0010_0000,
   parameter int          LINE_BYTES   = 1280,
   parameter int          LINES        = 480
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic                     ENABLE,
   input  logic                     FRAME_START,
   input  logic                     LINE_READY,
   cam_frame_sched_if.master        wr,
   input  logic                     RD_ACQ,
   input  logic                     RD_REL,
   output logic [1:0]               RD_BUF,
   output logic [31:0]              RD_ADRS,
   output logic                     RD_VALID,
   output logic                     FRAME_DONE,
   output logic [15:0]              OVERRUN_CNT,
   output logic                     BUSY
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FRAME,
      ST_WAIT_LINE,
      ST_ISSUE,
      ST_BUSY,
      ST_FRAME_END
   } state_t;

   localparam logic [31:0] LINE_INC  = 32'(LINE_BYTES);
   localparam logic [11:0] LAST_LINE = 12'(LINES - 1);

   state_t      state, state_n;
   logic [1:0]  wr_buf, latest, rd_buf, next_buf;
   logic [11:0] line_cnt;
   logic [31:0] line_addr, wr_adrs;
   logic        rd_locked, rd_valid, frame_done, wr_start, drop;
   logic [15:0] overrun_cnt;
   logic        overrun, acq_ok, lock_n;
   logic [1:0]  lock_buf_n;

   // Buffer base addresses come from a 3-way constant mux, never a multiplier
   function automatic logic [31:0] buf_base(input logic [1:0] b);
      case (b)
         2'd1:    return BASE_ADDR + FRAME_STRIDE;
         2'd2:    return BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;
         default: return BASE_ADDR;
      endcase
   endfunction

   // A vsync arriving once a frame is under way abandons that frame
   assign overrun = FRAME_START &&
                    ((state == ST_ISSUE) || (state == ST_BUSY) ||
                     ((state == ST_WAIT_LINE) && (line_cnt != 12'd0)));

   // Reader lock as it will be after this edge; a same-cycle acquire counts
   always_comb begin
      acq_ok     = RD_ACQ && rd_valid;
      lock_n     = acq_ok ? 1'b1 : (RD_REL ? 1'b0 : rd_locked);
      lock_buf_n = acq_ok ? latest : rd_buf;
      if ((wr_buf != 2'd0) && !(lock_n && (lock_buf_n == 2'd0)))
         next_buf = 2'd0;
      else if ((wr_buf != 2'd1) && !(lock_n && (lock_buf_n == 2'd1)))
         next_buf = 2'd1;
      else
         next_buf = 2'd2;
   end

   // Next-state decode for the line sequencer
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:
            if (ENABLE) state_n = ST_WAIT_FRAME;
         ST_WAIT_FRAME:
            if (!ENABLE)         state_n = ST_IDLE;
            else if (FRAME_START) state_n = ST_WAIT_LINE;
         ST_WAIT_LINE:
            if (!ENABLE)                         state_n = ST_IDLE;
            else if (overrun)                    state_n = ST_WAIT_LINE;
            else if (LINE_READY && wr.WR_READY)  state_n = ST_ISSUE;
         ST_ISSUE:
            state_n = ST_BUSY;
         ST_BUSY:
            if (wr.WR_DONE) begin
               if (drop || overrun)             state_n = ENABLE ? ST_WAIT_LINE : ST_IDLE;
               else if (line_cnt == LAST_LINE)  state_n = ST_FRAME_END;
               else if (!ENABLE)                state_n = ST_IDLE;
               else                             state_n = ST_WAIT_LINE;
            end
         ST_FRAME_END:
            state_n = ST_WAIT_FRAME;
         default:
            state_n = ST_IDLE;
      endcase
   end

   // State, line datapath, publication and reader-lock registers
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state       <= ST_IDLE;
         wr_buf      <= 2'd0;
         latest      <= 2'd0;
         line_cnt    <= 12'd0;
         line_addr   <= 32'd0;
         wr_adrs     <= 32'd0;
         wr_start    <= 1'b0;
         drop        <= 1'b0;
         rd_locked   <= 1'b0;
         rd_buf      <= 2'd0;
         rd_valid    <= 1'b0;
         frame_done  <= 1'b0;
         overrun_cnt <= 16'd0;
      end else begin
         state      <= state_n;
         wr_start   <= (state_n == ST_ISSUE);
         frame_done <= (state_n == ST_FRAME_END);
         if (state_n == ST_ISSUE)
            wr_adrs <= line_addr;

         case (state)
            ST_WAIT_FRAME:
               if (ENABLE && FRAME_START) begin
                  line_cnt  <= 12'd0;
                  line_addr <= buf_base(wr_buf);
               end
            ST_WAIT_LINE:
               if (overrun) begin
                  line_cnt  <= 12'd0;
                  line_addr <= buf_base(wr_buf);
               end
            ST_ISSUE:
               if (overrun) drop <= 1'b1;
            ST_BUSY:
               if (wr.WR_DONE) begin
                  if (drop || overrun) begin
                     line_cnt  <= 12'd0;
                     line_addr <= buf_base(wr_buf);
                     drop      <= 1'b0;
                  end else begin
                     line_cnt  <= line_cnt + 12'd1;
                     line_addr <= line_addr + LINE_INC;
                  end
               end else if (overrun) begin
                  drop <= 1'b1;
               end
            ST_FRAME_END: begin
               latest   <= wr_buf;
               rd_valid <= 1'b1;
               wr_buf   <= next_buf;
            end
            default: ;
         endcase

         if (overrun && (overrun_cnt != 16'hFFFF))
            overrun_cnt <= overrun_cnt + 16'd1;

         rd_locked <= lock_n;
         rd_buf    <= lock_buf_n;
      end
   end

   assign wr.WR_START  = wr_start;
   assign wr.WR_ADRS   = wr_adrs;
   assign wr.WR_LEN    = LINE_INC;
   assign RD_BUF       = rd_buf;
   assign RD_ADRS      = rd_valid ? buf_base(rd_buf) : 32'd0;
   assign RD_VALID     = rd_valid;
   assign FRAME_DONE   = frame_done;
   assign OVERRUN_CNT  = overrun_cnt;
   assign BUSY         = (state != ST_IDLE);

endmodule
